// File: rtl/fc_score_writer_if.sv
// fc_score_writer_if: score stream in, picture-memory write port and status out.
interface fc_score_writer_if #(
  parameter int ADDR_BIT = 10,
  parameter int ACC_BIT  = 32,
  parameter int DATA_BIT = 16
);
  logic                start;
  logic                in_valid;
  logic                in_ready;
  logic [ACC_BIT-1:0]  in_data;
  logic                mem_we;
  logic [ADDR_BIT-1:0] mem_addr;
  logic [DATA_BIT-1:0] mem_wdata;
  logic                busy;
  logic                sat_flag;
  logic                done;
  modport slave (
    input  start, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, sat_flag, done
  );
  modport master (
    output start, in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, sat_flag, done
  );
endinterface

// File: rtl/fc_score_writer.sv
// fc_score_writer: rescales/saturates NUM_CLASS scores into picture memory at BASE_ADDR.. and pulses done.
module fc_score_writer #(
  parameter int ADDR_BIT  = 10,
  parameter int ACC_BIT   = 32,
  parameter int DATA_BIT  = 16,
  parameter int SHIFT     = 8,
  parameter int BASE_ADDR = 16,
  parameter int NUM_CLASS = 10
) (
  input logic               clk,
  input logic               rst_n,
  fc_score_writer_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RECV, FLUSH, DONE} state_e;
  localparam logic signed [ACC_BIT-1:0] SMAX = ACC_BIT'((64'sd1 <<< (DATA_BIT-1)) - 64'sd1);
  localparam logic signed [ACC_BIT-1:0] SMIN = ~SMAX;
  state_e state_q, state_d;
  logic [ADDR_BIT-1:0] cnt_q, cnt_d, addr_q, addr_d;
  logic [DATA_BIT-1:0] wdata_q, wdata_d;
  logic we_q, we_d, sat_q, sat_d;
  logic signed [ACC_BIT-1:0] s;
  logic hi, lo, last;
  assign s    = $signed(bus.in_data) >>> SHIFT;
  assign hi   = s > SMAX;
  assign lo   = s < SMIN;
  assign last = cnt_q == ADDR_BIT'(NUM_CLASS - 1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = RECV;
        cnt_d   = '0;
        sat_d   = 1'b0;
      end
      RECV: if (bus.in_valid) begin
        we_d    = 1'b1;
        addr_d  = ADDR_BIT'(BASE_ADDR) + cnt_q;
        wdata_d = hi ? DATA_BIT'(SMAX) : lo ? DATA_BIT'(SMIN) : s[DATA_BIT-1:0];
        sat_d   = sat_q | hi | lo;
        cnt_d   = cnt_q + ADDR_BIT'(1);
        state_d = last ? FLUSH : RECV;
      end
      FLUSH:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      sat_q   <= sat_d;
    end
  assign bus.in_ready  = state_q == RECV;
  assign bus.busy      = state_q != IDLE;
  assign bus.done      = state_q == DONE;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.sat_flag  = sat_q;
endmodule

// File: tb/tb_fc_score_writer.sv
// tb_fc_score_writer: directed frames against hand-computed write logs for default and single-class variants.
module tb_fc_score_writer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int wa[$], wd[$], wc[$], dc[$], hs[$];
  logic [15:0] e [10];
  int gap [10] = '{0, 2, 0, 1, 3, 0, 0, 1, 2, 0};
  fc_score_writer_if #(.ADDR_BIT(10), .ACC_BIT(32), .DATA_BIT(16)) bus ();
  fc_score_writer_if #(.ADDR_BIT(10), .ACC_BIT(32), .DATA_BIT(16)) bus1 ();
  fc_score_writer dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  fc_score_writer #(.NUM_CLASS(1), .SHIFT(0), .BASE_ADDR(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.mem_we) begin
      wa.push_back(int'(bus.mem_addr));
      wd.push_back(int'(bus.mem_wdata));
      wc.push_back(cyc);
    end
    if (bus.done) dc.push_back(cyc);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clear();
    wa.delete(); wd.delete(); wc.delete(); dc.delete(); hs.delete();
  endtask
  task automatic start_frame();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask
  task automatic send(input logic [31:0] d);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!bus.in_ready && t < 20) begin step(); t++; end
    check("ready", bus.in_ready, 1);
    hs.push_back(cyc + 1);
    step();
  endtask
  task automatic end_frame();
    int t = 0;
    while (!bus.done && t < 50) begin step(); t++; end
    check("done_seen", bus.done, 1);
    step();
    check("busy_idle", bus.busy, 0);
    step();
  endtask
  task automatic check_frame(input string tag, input logic [15:0] ex [10]);
    check({tag, "_nwr"}, wa.size(), 10);
    for (int k = 0; k < 10 && k < wa.size(); k++) begin
      check($sformatf("%s_addr%0d", tag, k), wa[k], 16 + k);
      check($sformatf("%s_data%0d", tag, k), wd[k], {16'h0, ex[k]});
      if (k < hs.size()) check($sformatf("%s_wcyc%0d", tag, k), wc[k], hs[k]);
    end
    check({tag, "_ndone"}, dc.size(), 1);
    if (dc.size() > 0 && hs.size() == 10) check({tag, "_done_cyc"}, dc[0], hs[9] + 1);
  endtask
  task automatic send1(input logic [31:0] d, input logic [15:0] exp, input logic exp_sat);
    bus1.start = 1'b1;
    step();
    bus1.start = 1'b0;
    bus1.in_valid = 1'b1;
    bus1.in_data  = d;
    check("v_ready", bus1.in_ready, 1);
    step();
    bus1.in_valid = 1'b0;
    check("v_we", bus1.mem_we, 1);
    check("v_addr", bus1.mem_addr, 0);
    check("v_data", bus1.mem_wdata, exp);
    check("v_sat", bus1.sat_flag, exp_sat);
    check("v_done_early", bus1.done, 0);
    check("v_ready_flush", bus1.in_ready, 0);
    step();
    check("v_done", bus1.done, 1);
    check("v_we_done", bus1.mem_we, 0);
    step();
    check("v_busy", bus1.busy, 0);
    check("v_done_once", bus1.done, 0);
  endtask
  initial begin
    bus.start = 0; bus.in_valid = 0; bus.in_data = '0;
    bus1.start = 0; bus1.in_valid = 0; bus1.in_data = '0;
    step(); step();
    check("rst_we", bus.mem_we, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_wdata", bus.mem_wdata, 0);
    check("rst_ready", bus.in_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_sat", bus.sat_flag, 0);
    rst_n = 1'b1;
    step();
    clear();
    start_frame();
    check("a_busy", bus.busy, 1);
    for (int k = 0; k < 10; k++) send(32'h100 * k);
    bus.in_valid = 1'b0;
    end_frame();
    check("a_sat", bus.sat_flag, 0);
    for (int k = 0; k < 10; k++) e[k] = 16'(k);
    check_frame("a", e);
    clear();
    start_frame();
    send(32'h7FFF_FFFF);
    check("s_sat_first", bus.sat_flag, 1);
    send(32'h8000_0000);
    send(32'hFFFF_0000);
    send(32'h0000_1234);
    for (int k = 4; k < 10; k++) send(32'h0);
    bus.in_valid = 1'b0;
    end_frame();
    check("s_sat_sticky", bus.sat_flag, 1);
    e = '{16'h7FFF, 16'h8000, 16'hFF00, 16'h0012, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    check_frame("s", e);
    clear();
    start_frame();
    check("g_sat_clear", bus.sat_flag, 0);
    for (int k = 0; k < 10; k++) begin
      for (int g = 0; g < gap[k]; g++) begin bus.in_valid = 1'b0; step(); end
      send(32'hFFFF_F000 + 32'h100 * k);
    end
    bus.in_valid = 1'b0;
    end_frame();
    for (int k = 0; k < 10; k++) e[k] = 16'hFFF0 + 16'(k);
    check_frame("g", e);
    clear();
    bus.start = 1'b1;
    step();
    for (int k = 0; k < 10; k++) send(32'h1_0000 * k);
    check("x_ready_flush", bus.in_ready, 0);
    check("x_busy_flush", bus.busy, 1);
    step();
    check("x_done", bus.done, 1);
    check("x_ready_done", bus.in_ready, 0);
    bus.start = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("x_busy_after", bus.busy, 0);
    check("x_ready_idle", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    for (int k = 0; k < 10; k++) e[k] = 16'h100 * 16'(k);
    check_frame("x", e);
    clear();
    start_frame();
    for (int k = 0; k < 4; k++) send(32'h100 * (k + 1));
    bus.in_valid = 1'b0;
    step();
    check("r_addr_pre", bus.mem_addr, 19);
    #2 rst_n = 1'b0;
    #1;
    check("r_we", bus.mem_we, 0);
    check("r_addr", bus.mem_addr, 0);
    check("r_wdata", bus.mem_wdata, 0);
    check("r_busy", bus.busy, 0);
    check("r_ready", bus.in_ready, 0);
    check("r_done", bus.done, 0);
    step(); step();
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) step();
    bus.in_valid = 1'b0;
    check("r_nwr", wa.size(), 4);
    check("r_busy_after", bus.busy, 0);
    clear();
    start_frame();
    for (int k = 0; k < 10; k++) send(32'h100 * k);
    bus.in_valid = 1'b0;
    end_frame();
    for (int k = 0; k < 10; k++) e[k] = 16'(k);
    check_frame("p", e);
    send1(32'h0000_1234, 16'h1234, 1'b0);
    send1(32'hFFFF_8000, 16'h8000, 1'b0);
    send1(32'h0000_8000, 16'h7FFF, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
